// File: rtl/serial_addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_addsub_pkg
// Purpose  : Shared definitions for the digit-serial adder/subtractor.
//            Holds the state encoding and helpers that derive the digit count
//            and the digit-counter width from WIDTH/DIGIT.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package serial_addsub_pkg;

  // Controller state encoding
  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  // Number of DIGIT-bit slices needed to cover WIDTH bits
  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction

  // Digit counter width; never narrower than one bit so N=1 still elaborates
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_addsub_digit_adder.sv
`default_nettype none
// ============================================================================
// Module   : digit_adder
// Purpose  : Combinational DIGIT-bit ripple chain of full adders.
// Ports    : a, b      - DIGIT-bit operands
//            cin       - carry into bit 0
//            s         - DIGIT-bit sum
//            cout      - carry out of the top bit
//            c_msb_in  - carry into the top bit (signed-overflow detection)
// Revision : 1.0 - initial release
// ============================================================================
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  // w_c[i] is the carry into bit i; w_c[DIGIT] leaves the slice
  logic [DIGIT:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign s[i]     = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign cout     = w_c[DIGIT];
  assign c_msb_in = w_c[DIGIT-1];

endmodule
`default_nettype wire

// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
// Module   : serial_addsub
// Purpose  : Digit-serial adder/subtractor. One DIGIT-bit ripple slice and a
//            registered carry process the operands LSB digit first over
//            WIDTH/DIGIT clocks, with a start/busy/done handshake.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            start           - request, sampled only while not busy
//            sub             - 0: a+b+cin, 1: a-b-cin
//            a, b, cin       - operands, sampled with an accepted start
//            busy            - high while the operation runs
//            done            - one-cycle pulse when a new result is valid
//            sum, cout, ovf  - result, carry (no-borrow for sub), overflow
// Revision : 1.0 - initial release
// ============================================================================
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int c_NUM_DIGITS = num_digits(WIDTH, DIGIT);
  localparam int c_CNT_W      = cnt_width(c_NUM_DIGITS);

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [WIDTH-1:0]   r_op_a;
  logic [WIDTH-1:0]   r_op_b;
  logic [WIDTH-1:0]   r_psum;
  logic               r_carry;
  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;

  logic [DIGIT-1:0]   w_slice_s;
  logic               w_slice_cout;
  logic               w_slice_c_msb;
  logic [WIDTH-1:0]   w_psum_nxt;
  logic               w_accept;
  logic               w_last;

  digit_adder #(
    .DIGIT (DIGIT)
  ) u_digit_adder (
    .a        (r_op_a[DIGIT-1:0]),
    .b        (r_op_b[DIGIT-1:0]),
    .cin      (r_carry),
    .s        (w_slice_s),
    .cout     (w_slice_cout),
    .c_msb_in (w_slice_c_msb)
  );

  // A start is taken in IDLE and also in DONE, which allows back-to-back ops
  assign w_accept = start && ((r_state == c_IDLE) || (r_state == c_DONE));
  assign w_last   = (r_state == c_RUN) && (r_cnt == c_CNT_W'(c_NUM_DIGITS - 1));

  // New slice sum enters at the top; after N shifts the LSB digit sits at bit 0
  assign w_psum_nxt = (r_psum >> DIGIT) | (WIDTH'(w_slice_s) << (WIDTH - DIGIT));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  w_state_nxt = start  ? c_RUN  : c_IDLE;
      c_RUN:   w_state_nxt = w_last ? c_DONE : c_RUN;
      c_DONE:  w_state_nxt = start  ? c_RUN  : c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (r_state == c_RUN);
    done = (r_state == c_DONE);
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_psum  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      // Subtraction is a + ~b + ~cin: invert B and the borrow-in once here
      r_op_a  <= a;
      r_op_b  <= sub ? ~b : b;
      r_carry <= sub ? ~cin : cin;
      r_cnt   <= '0;
    end else if (r_state == c_RUN) begin
      r_op_a  <= r_op_a >> DIGIT;
      r_op_b  <= r_op_b >> DIGIT;
      r_psum  <= w_psum_nxt;
      r_carry <= w_slice_cout;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        // Results are published only on the final digit so they stay stable
        // for the whole run
        r_sum  <= w_psum_nxt;
        r_cout <= w_slice_cout;
        r_ovf  <= w_slice_c_msb ^ w_slice_cout;
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_addsub
// Purpose  : Scoreboard bench for serial_addsub at WIDTH=16 with DIGIT=4,
//            DIGIT=1 and DIGIT=16 instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_addsub;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [2:0]   start_v = 3'b000;
  logic         sub = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;

  logic         busy_v [3];
  logic         done_v [3];
  logic         cout_v [3];
  logic         ovf_v  [3];
  logic [W-1:0] sum_v  [3];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  exp_t         q [3][$];
  logic [W-1:0] last_sum  [3];
  logic         last_cout [3];
  logic         last_ovf  [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_addsub #(.WIDTH(W), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0]));
  serial_addsub #(.WIDTH(W), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1]));
  serial_addsub #(.WIDTH(W), .DIGIT(16)) u_d16 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2]));

  function automatic int n_of(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 16 : 1);
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed interpretations
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mc, input logic ms);
    exp_t e;
    int ua, ub, sa, sb, c, ru, rs;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    c  = mc ? 1 : 0;
    if (!ms) begin
      ru = ua + ub + c;
      rs = sa + sb + c;
      e.cout = (ru >= 65536);
    end else begin
      ru = ua - ub - c;
      rs = sa - sb - c;
      e.cout = (ru >= 0);
    end
    e.sum = W'(ru);
    e.ovf = (rs > 32767) || (rs < -32768);
    e.cyc = 0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at #1 after an edge: the next edge samples these inputs
  task automatic push_exp(input int i, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tc, input logic ts);
    exp_t e;
    e = model(ta, tb_, tc, ts);
    e.cyc = cyc + 1 + n_of(i);
    q[i].push_back(e);
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        input logic ts, input logic [2:0] mask, input int wait_n);
    a = ta; b = tb_; cin = tc; sub = ts; start_v = mask;
    for (int i = 0; i < 3; i++) if (mask[i]) push_exp(i, ta, tb_, tc, ts);
    @(posedge clk); #1;
    start_v = 3'b000;
    repeat (wait_n) @(posedge clk);
    #1;
  endtask

  task automatic clear_last();
    for (int i = 0; i < 3; i++) begin
      last_sum[i] = '0; last_cout[i] = 1'b0; last_ovf[i] = 1'b0;
    end
  endtask

  // Monitor: pops on every done, and checks outputs hold while running
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done_v[i] === 1'b1) begin
        if (q[i].size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done inst=%0d: got done=1 expected none (cycle %0d)", i, cyc);
        end else begin
          exp_t e;
          e = q[i].pop_front();
          chk($sformatf("sum[%0d]", i), 32'(sum_v[i]), 32'(e.sum));
          chk($sformatf("cout[%0d]", i), 32'(cout_v[i]), 32'(e.cout));
          chk($sformatf("ovf[%0d]", i), 32'(ovf_v[i]), 32'(e.ovf));
          chk($sformatf("done_cycle[%0d]", i), 32'(cyc), 32'(e.cyc));
          chk($sformatf("busy_with_done[%0d]", i), 32'(busy_v[i]), 32'(0));
          last_sum[i] = e.sum; last_cout[i] = e.cout; last_ovf[i] = e.ovf;
        end
      end else if (busy_v[i] === 1'b1) begin
        chk($sformatf("hold_sum[%0d]", i), 32'(sum_v[i]), 32'(last_sum[i]));
        chk($sformatf("hold_flags[%0d]", i), 32'({cout_v[i], ovf_v[i]}),
            32'({last_cout[i], last_ovf[i]}));
      end
    end
  end

  initial begin
    clear_last();
    #2;
    chk("reset_busy", 32'(busy_v[0]), 32'(0));
    chk("reset_done", 32'(done_v[0]), 32'(0));
    chk("reset_sum",  32'(sum_v[0]),  32'(0));
    chk("reset_cout", 32'(cout_v[0]), 32'(0));
    chk("reset_ovf",  32'(ovf_v[0]),  32'(0));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases on the DIGIT=4 instance
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 3'b001, 5);
    run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 3'b001, 5);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 3'b001, 5);
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 3'b001, 5);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 3'b001, 5);

    // Start pulses during RUN with other operands must be ignored
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; start_v = 3'b001;
    push_exp(0, 16'h1111, 16'h2222, 1'b0, 1'b0);
    @(posedge clk); #1;
    a = 16'hABCD; b = 16'h9876; cin = 1'b1; sub = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    start_v = 3'b000;
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back: start held high, operands change every cycle
    start_v = 3'b001;
    for (int j = 0; j < 15; j++) begin
      a = W'($urandom()); b = W'($urandom());
      cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      if (j % 5 == 0) push_exp(0, a, b, cin, sub);
      @(posedge clk); #1;
    end
    start_v = 3'b000;
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset while digit 2 is being processed
    a = 16'h4444; b = 16'h3333; cin = 1'b0; sub = 1'b0; start_v = 3'b001;
    @(posedge clk); #1;
    start_v = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_busy", 32'(busy_v[0]), 32'(0));
    chk("midrun_reset_done", 32'(done_v[0]), 32'(0));
    chk("midrun_reset_sum",  32'(sum_v[0]),  32'(0));
    chk("midrun_reset_cout", 32'(cout_v[0]), 32'(0));
    chk("midrun_reset_ovf",  32'(ovf_v[0]),  32'(0));
    clear_last();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 3'b001, 5);

    // Random operations on all three digit sizes
    for (int k = 0; k < 20; k++) begin
      run_op(W'($urandom()), W'($urandom()), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 3'b111, 17);
    end

    // Every issued operation must have produced its done
    repeat (20) @(posedge clk);
    #1;
    chk("pending_results", 32'(q[0].size() + q[1].size() + q[2].size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
